fp_mult: RTL and testbench
==========================

Name: fp_mult

Overview:
- Pipelined IEEE-754 single-precision (binary32) multiplier.
- Used as the multiply element of the systolic-array processing element.
- Accepts one operand pair per clock and produces out_r = in_a × in_b.
- Fixed 3-stage latency, round-to-nearest-even, subnormals flushed to zero.

Parameters:
None. Format (binary32), latency (3) and rounding mode (RNE) are fixed.

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous, active-high reset
in_a  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0])
in_b  input  32  operand B, binary32
out_r  output  32  product, binary32, registered

Behaviour:
- Reset:
  - rst sampled high at a rising edge clears all pipeline registers; out_r = 32'h0000_0000.
  - Reset mid-operation discards every in-flight product.
  - After rst deasserts, out_r stays 0 until the first post-reset operands reach the output.
- Pipeline and throughput:
  - Full throughput, no stall or handshake; a new operand pair is sampled every edge.
  - Stage 1 (edge N): register in_a/in_b; decode sign, exponent, hidden bit and special class.
  - Stage 2 (edge N+1): 24×24 unsigned mantissa product (48 bits); exp sum = ea + eb − 127; sign = sa ^ sb.
  - Stage 3 (edge N+2): normalize, round, detect overflow/underflow, select special result, register out_r.
  - The result of operands applied before edge N is visible on out_r just after edge N+2.
- Normalization:
  - If product bit 47 is set: take mantissa bits [46:24] and increment the exponent; guard = bit 23; sticky = OR[22:0].
  - Otherwise: take mantissa bits [45:23]; guard = bit 22; sticky = OR[21:0].
  - Round bit merged into sticky.
- Rounding (RNE):
  - Increment if guard && (sticky || lsb).
  - A mantissa carry-out sets the mantissa to 0 and increments the exponent.
- Overflow: final biased exponent ≥ 255 → signed infinity (exp = FF, frac = 0).
- Underflow: final biased exponent ≤ 0 → signed zero (flush to zero, no subnormal output).
- Input classes:
  - exp = 0 (zero or subnormal) is treated as zero of that sign.
  - exp = FF with frac ≠ 0 is NaN.
- Special-case priority:
  - Any NaN input → canonical 32'h7FC0_0000.
  - Inf × zero → 32'h7FC0_0000.
  - Inf × nonzero → infinity with sign sa ^ sb.
  - Zero × finite → zero with sign sa ^ sb (−0 allowed).
- No internal state beyond the pipeline registers; results are a pure function of inputs delayed by the pipeline.

Optional Feature:
- Macro FP_MULT_FLAGS_EN.
- When defined, adds output port out_flags[3:0] = {invalid, overflow, underflow, inexact}.
  - Pipelined alongside out_r, same latency; reset to 0.
  - invalid: NaN input or inf × 0.
  - overflow: result forced to infinity by exponent range (not set for infinity operands).
  - underflow: nonzero result flushed to zero.
  - inexact: guard or sticky set, or overflow, or underflow.
- When undefined, the port and its logic are absent; out_r behaviour is identical.

Test Plan:
- rst high 2 cycles with in_a = in_b = 0 → out_r = 0. Release rst, apply 0x40000000 × 0x40000000 → out_r = 0x40800000 two edges after the sampling edge.
- Back-to-back, one pair per cycle:
  - 0x40800000², expect 0x41800000
  - 0x41000000², expect 0x42800000
  - 0x41800000², expect 0x43800000
  - 0x42800000², expect 0x45800000
  - Results appear on consecutive cycles in order.
- Sign and rounding:
  - 0xC0000000 × 0x40800000 → 0xC1000000.
  - 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE, inexact).
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x3F000000 → 0x00000000.
  - 0x80000000 × 0x40000000 → 0x80000000.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x7FC12345 × 0x3F800000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Assert rst while three products are in flight → out_r = 0 on the next edge and no stale result appears afterwards.

Source files
------------

// File: rtl/fp_mult.sv
// rtl/fp_mult.sv - 3-stage binary32 multiplier, RNE, flush-to-zero; FP_MULT_FLAGS_EN adds out_flags
module fp_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] out_r
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic [3:0]  out_flags
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Stage 1 registers: decoded operand fields and class
  logic        s1_sign_a, s1_sign_b;
  logic [7:0]  s1_exp_a, s1_exp_b;
  logic [23:0] s1_man_a, s1_man_b;
  logic        s1_zero_a, s1_zero_b;
  logic        s1_inf_a, s1_inf_b;
  logic        s1_nan_a, s1_nan_b;

  // Stage 2 registers: raw product, unnormalized exponent, resolved special class
  logic        s2_sign;
  logic signed [9:0] s2_exp;
  logic [47:0] s2_prod;
  logic        s2_nan;
  logic        s2_inf;
  logic        s2_zero;

  // Stage 2 combinational helpers
  logic signed [9:0] exp_sum;

  // Stage 3 combinational helpers
  logic        norm_hi;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;
  logic [22:0] frac_r;
  logic        ovf;
  logic        unf;
  logic        finite;
  logic [31:0] result_nxt;
`ifdef FP_MULT_FLAGS_EN
  logic [3:0]  flags_nxt;
`endif

  // Stage 1: capture operands already split into sign, exponent, mantissa and class
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_exp_a  <= 8'd0;
      s1_exp_b  <= 8'd0;
      s1_man_a  <= 24'd0;
      s1_man_b  <= 24'd0;
      s1_zero_a <= 1'b1;
      s1_zero_b <= 1'b1;
      s1_inf_a  <= 1'b0;
      s1_inf_b  <= 1'b0;
      s1_nan_a  <= 1'b0;
      s1_nan_b  <= 1'b0;
    end else begin
      s1_sign_a <= in_a[31];
      s1_sign_b <= in_b[31];
      s1_exp_a  <= in_a[30:23];
      s1_exp_b  <= in_b[30:23];
      // subnormals get no hidden bit; they are treated as zero downstream
      s1_man_a  <= {(in_a[30:23] != 8'd0), in_a[22:0]};
      s1_man_b  <= {(in_b[30:23] != 8'd0), in_b[22:0]};
      s1_zero_a <= (in_a[30:23] == 8'd0);
      s1_zero_b <= (in_b[30:23] == 8'd0);
      s1_inf_a  <= (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
      s1_inf_b  <= (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
      s1_nan_a  <= (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
      s1_nan_b  <= (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    end
  end

  // Biased exponent sum kept signed and wide enough for both range extremes
  always_comb begin
    exp_sum = $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - 10'sd127;
  end

  // Stage 2: mantissa product, exponent sum, result sign and special-class resolution
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign <= 1'b0;
      s2_exp  <= 10'sd0;
      s2_prod <= 48'd0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      // a cleared pipeline represents 0 x 0, so the zero class keeps flags quiet
      s2_zero <= 1'b1;
    end else begin
      s2_sign <= s1_sign_a ^ s1_sign_b;
      s2_exp  <= exp_sum;
      s2_prod <= {24'd0, s1_man_a} * {24'd0, s1_man_b};
      s2_nan  <= s1_nan_a | s1_nan_b | (s1_inf_a & s1_zero_b) | (s1_inf_b & s1_zero_a);
      s2_inf  <= s1_inf_a | s1_inf_b;
      s2_zero <= s1_zero_a | s1_zero_b;
    end
  end

  // Stage 3 datapath: normalize, round to nearest even, range check, special select
  always_comb begin
    norm_hi = s2_prod[47];
    if (norm_hi) begin
      mant   = s2_prod[46:24];
      guard  = s2_prod[23];
      sticky = |s2_prod[22:0];
      exp_n  = s2_exp + 10'sd1;
    end else begin
      mant   = s2_prod[45:23];
      guard  = s2_prod[22];
      sticky = |s2_prod[21:0];
      exp_n  = s2_exp;
    end

    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    // carry out of the fraction means 1.111..1 rounded up to 10.000..0
    exp_r    = mant_rnd[23] ? (exp_n + 10'sd1) : exp_n;
    frac_r   = mant_rnd[23] ? 23'd0 : mant_rnd[22:0];

    ovf    = (exp_r > 10'sd254);
    unf    = (exp_r < 10'sd1);
    finite = !s2_nan && !s2_inf && !s2_zero;

    if (s2_nan) begin
      result_nxt = QNAN;
    end else if (s2_inf) begin
      result_nxt = {s2_sign, 8'hFF, 23'd0};
    end else if (s2_zero) begin
      result_nxt = {s2_sign, 31'd0};
    end else if (ovf) begin
      result_nxt = {s2_sign, 8'hFF, 23'd0};
    end else if (unf) begin
      result_nxt = {s2_sign, 31'd0};
    end else begin
      result_nxt = {s2_sign, exp_r[7:0], frac_r};
    end

`ifdef FP_MULT_FLAGS_EN
    flags_nxt = {s2_nan,
                 finite & ovf,
                 finite & unf,
                 finite & (guard | sticky | ovf | unf)};
`endif
  end

  // Stage 3 register: the only architecturally visible state
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= 32'h0000_0000;
    end else begin
      out_r <= result_nxt;
    end
  end

`ifdef FP_MULT_FLAGS_EN
  // Exception flags travel alongside out_r with identical latency
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= 4'd0;
    end else begin
      out_flags <= flags_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mult.sv
// tb/tb_fp_mult.sv - scoreboard bench for fp_mult with integer reference model
module tb_fp_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] out_r;
`ifdef FP_MULT_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  fp_mult dut (
    .clk   (clk),
    .rst   (rst),
    .in_a  (in_a),
    .in_b  (in_b),
    .out_r (out_r)
`ifdef FP_MULT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [35:0] exp_q[$];
  logic        issue = 1'b0;
  logic [2:0]  vpipe = 3'd0;
  logic        mon_rst;
  logic [35:0] mon_e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: exact integer product, round by comparing the remainder to half an ulp
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s;
    int ea, eb, e, msb, sh;
    longint ma, mb, p, kept, rem, half;
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    sa = a[31]; sb = b[31]; s = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    nan_a  = (ea == 255) && (a[22:0] != 0);
    nan_b  = (eb == 255) && (b[22:0] != 0);
    inf_a  = (ea == 255) && (a[22:0] == 0);
    inf_b  = (eb == 255) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      return {4'b1000, 32'h7FC0_0000};
    if (inf_a || inf_b) return {4'b0000, s, 8'hFF, 23'd0};
    if (zero_a || zero_b) return {4'b0000, s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    p = ma * mb;
    msb = -1;
    for (int i = 47; i >= 0; i--) if (p[i] && msb < 0) msb = i;
    sh   = msb - 23;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    e = ea + eb - 127 + (msb - 46);
    if (kept == (longint'(1) << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0011, s, 31'd0};
    return {3'b000, (rem != 0), s, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 9))
      0: return $urandom();
      1: begin
        case ($urandom_range(0, 6))
          0: return 32'h0000_0000;
          1: return 32'h8000_0000;
          2: return 32'h7F80_0000;
          3: return 32'hFF80_0000;
          4: return 32'h7FC0_0000;
          5: return 32'h0040_0000;
          default: return 32'hFF80_0001;
        endcase
      end
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(40, 215)), 23'($urandom())};
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = 1'b0; in_a = a; in_b = b; issue = 1'b1;
    exp_q.push_back(ref_mul(a, b));
  endtask

  // Directed vector: result word is a hand-derived constant, flags come from the model
  task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    logic [35:0] m;
    m = ref_mul(a, b);
    @(negedge clk);
    rst = 1'b0; in_a = a; in_b = b; issue = 1'b1;
    exp_q.push_back({m[35:32], r});
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst = 1'b1; in_a = 32'd0; in_b = 32'd0; issue = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; in_a = 32'd0; in_b = 32'd0; issue = 1'b0;
    end
  endtask

  // Monitor: tracks which edges carry issued operands and checks out_r three edges later
  always begin
    @(posedge clk);
    mon_rst = rst;
    if (mon_rst) begin
      vpipe = 3'd0;
      exp_q.delete();
    end else begin
      vpipe = {vpipe[1:0], issue};
    end
    #1;
    if (mon_rst || !vpipe[2]) begin
      check32("idle_zero", out_r, 32'd0);
`ifdef FP_MULT_FLAGS_EN
      check32("idle_flags", {28'd0, out_flags}, 32'd0);
`endif
    end else if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got output %h with nothing expected", out_r);
    end else begin
      mon_e = exp_q.pop_front();
      check32("out_r", out_r, mon_e[31:0]);
`ifdef FP_MULT_FLAGS_EN
      check32("out_flags", {28'd0, out_flags}, {28'd0, mon_e[35:32]});
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_cycle();
    rst_cycle();
    drive_exp(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    drive_exp(32'h4080_0000, 32'h4080_0000, 32'h4180_0000);
    drive_exp(32'h4100_0000, 32'h4100_0000, 32'h4280_0000);
    drive_exp(32'h4180_0000, 32'h4180_0000, 32'h4380_0000);
    drive_exp(32'h4280_0000, 32'h4280_0000, 32'h4580_0000);
    drive_exp(32'hC000_0000, 32'h4080_0000, 32'hC100_0000);
    drive_exp(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    drive_exp(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    drive_exp(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
    drive_exp(32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    drive_exp(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    drive_exp(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    drive_exp(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    drive_exp(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
    idle(4);

    // reset with products in flight: none of them may surface
    drive(32'h4000_0000, 32'h4040_0000);
    drive(32'h4040_0000, 32'h4040_0000);
    drive(32'hC0A0_0000, 32'h4000_0000);
    rst_cycle();
    idle(5);

    for (int i = 0; i < 400; i++) drive(rand_op(), rand_op());
    idle(5);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending results required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
